// File: rtl/parity_link_pkg.sv
// rtl/parity_link_pkg.sv - shared FSM encoding and framing constants for the parity serial link
package parity_link_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/xor_1b.sv
// rtl/xor_1b.sv - single-bit exclusive-or cell shared by both ends of the link
module xor_1b (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = (a & ~b) | (~a & b);

endmodule

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial frame receiver with parity and framing checks
// Build option: PARITY_ODD_EN selects odd parity instead of even.
import parity_link_pkg::*;

module parity_frame_rx #(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef PARITY_ODD_EN
    localparam logic ACC_INIT = 1'b1;
`else
    localparam logic ACC_INIT = 1'b0;
`endif

    rx_state_t          state;
    logic [CNT_W-1:0]   bit_cnt;
    logic               acc;
    logic               mismatch;
    logic [DATA_W-1:0]  shreg;
    logic               acc_next;
    logic               mismatch_next;

    xor_1b u_acc_xor (
        .a (acc),
        .b (rx_bit),
        .y (acc_next)
    );

    xor_1b u_par_xor (
        .a (acc),
        .b (rx_bit),
        .y (mismatch_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            acc        <= ACC_INIT;
            mismatch   <= 1'b0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        if (rx_bit == START_BIT) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            acc     <= ACC_INIT;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        // right shift so the first data bit lands at the LSB
                        shreg   <= {rx_bit, shreg[DATA_W-1:1]};
                        acc     <= acc_next;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(DATA_W - 1))
                            state <= PARITY;
                    end
                    PARITY: begin
                        mismatch <= mismatch_next;
                        state    <= STOP;
                    end
                    STOP: begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        data_valid <= 1'b1;
                        data_out   <= shreg;
                        parity_err <= mismatch;
                        frame_err  <= (rx_bit != STOP_BIT);
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - self-checking bench for parity_frame_rx
module tb_parity_frame_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic          rx_bit;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    parity_frame_rx #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_bit     (rx_bit),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (data_valid === 1'b1) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: count the ones in data plus parity bit.
    function automatic logic model_perr(input logic [DW-1:0] d, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
`ifdef PARITY_ODD_EN
        return (ones % 2) == 0;
`else
        return (ones % 2) == 1;
`endif
    endfunction

    function automatic logic good_parity(input logic [DW-1:0] d);
`ifdef PARITY_ODD_EN
        return ($countones(d) % 2) == 0;
`else
        return ($countones(d) % 2) == 1;
`endif
    endfunction

    // Called at a falling edge: drive one qualified bit, then optional idle cycles.
    task automatic send_bit(input logic b, input int gap);
        rx_valid = 1'b1;
        rx_bit   = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < DW; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(s, 0);
    endtask

    task automatic check_frame(input string tag, input logic [DW-1:0] d, input logic p, input logic s);
        chk({tag, ".valid"}, 32'(data_valid), 32'd1);
        chk({tag, ".data"},  32'(data_out),   32'(d));
        chk({tag, ".perr"},  32'(parity_err), 32'(model_perr(d, p)));
        chk({tag, ".ferr"},  32'(frame_err),  32'(s == 1'b0));
        chk({tag, ".busy"},  32'(busy),       32'd0);
        rx_valid = 1'b0;
        rx_bit   = 1'b1;
    endtask

    initial begin
        int p0;
        logic [DW-1:0] d;
        logic p, s;
        int gap;

        rst = 1'b1; rx_valid = 1'b0; rx_bit = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.data",  32'(data_out),   32'd0);
        chk("rst.valid", 32'(data_valid), 32'd0);
        chk("rst.perr",  32'(parity_err), 32'd0);
        chk("rst.ferr",  32'(frame_err),  32'd0);
        chk("rst.busy",  32'(busy),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        // clean frame, gap-free
        send_frame(8'hA5, good_parity(8'hA5), 1'b1, 0);
        check_frame("t1", 8'hA5, good_parity(8'hA5), 1'b1);
        @(negedge clk);
        chk("t1.pulse_len", 32'(data_valid), 32'd0);

        // parity error then clean frame clears it
        send_frame(8'h07, 1'b0, 1'b1, 0);
        check_frame("t2a", 8'h07, 1'b0, 1'b1);
        @(negedge clk);
        send_frame(8'h00, good_parity(8'h00), 1'b1, 0);
        check_frame("t2b", 8'h00, good_parity(8'h00), 1'b1);
        @(negedge clk);

        // framing error
        send_frame(8'h3C, good_parity(8'h3C), 1'b0, 0);
        check_frame("t3", 8'h3C, good_parity(8'h3C), 1'b0);
        repeat (2) @(negedge clk);

        // stalls between every bit
        p0 = pulses;
        send_frame(8'h5A, good_parity(8'h5A), 1'b1, 3);
        check_frame("t4", 8'h5A, good_parity(8'h5A), 1'b1);
        repeat (4) @(negedge clk);
        chk("t4.pulses", 32'(pulses - p0), 32'd1);
        chk("t4.hold",   32'(data_out),    32'h5A);

        // idle ones, then back-to-back frames
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, 0);
            chk("t5.idle_busy", 32'(busy), 32'd0);
        end
        p0 = pulses;
        send_frame(8'h81, good_parity(8'h81), 1'b1, 0);
        check_frame("t5a", 8'h81, good_parity(8'h81), 1'b1);
        send_frame(8'hFF, good_parity(8'hFF), 1'b1, 0);
        check_frame("t5b", 8'hFF, good_parity(8'hFF), 1'b1);
        repeat (3) @(negedge clk);
        chk("t5.pulses", 32'(pulses - p0), 32'd2);

        // reset mid-frame
        p0 = pulses;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        chk("t6.busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6.rst_busy", 32'(busy),     32'd0);
        chk("t6.rst_data", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6.no_pulse", 32'(pulses - p0), 32'd0);
        send_frame(8'h12, good_parity(8'h12), 1'b1, 0);
        check_frame("t6a", 8'h12, good_parity(8'h12), 1'b1);
        @(negedge clk);
        send_frame(8'h12, ~good_parity(8'h12), 1'b1, 0);
        check_frame("t6b", 8'h12, ~good_parity(8'h12), 1'b1);
        @(negedge clk);

        // randomized frames against the counting model
        for (int n = 0; n < 24; n++) begin
            d   = DW'($urandom);
            p   = 1'($urandom);
            s   = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 2);
            p0  = pulses;
            send_frame(d, p, s, gap);
            check_frame("rnd", d, p, s);
            repeat (2) @(negedge clk);
            chk("rnd.pulses", 32'(pulses - p0), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
